// File: rtl/tt_lut_gate.sv
// ============================================================================
// Module   : tt_lut_gate
// Brief    : Registered truth-table gate with a serial, atomically committed
//            table loader. Optional input glitch filter enabled by the macro
//            TT_LUT_GATE_GLITCH_FILTER_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tt_lut_gate #(
  parameter int                    N_IN    = 4,
  parameter logic [(1<<N_IN)-1:0]  TT_INIT = 16'h0038,
  parameter int                    SETTLE  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] in,
  output logic            out,
  output logic            out_valid,
  input  logic            tt_valid,
  input  logic            tt_data,
  input  logic            tt_last,
  output logic            tt_ready,
  output logic            tt_err
);

  localparam int               W        = 1 << N_IN;
  localparam logic [N_IN-1:0]  LAST_IDX = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] cnt_q, cnt_d;
  logic [W-1:0]    shadow_q, shadow_d;
  logic [W-1:0]    tt_q, tt_d;
  logic            err_q, err_d;
  logic            out_q, out_d;
  logic            valid_q, valid_d;
  logic            started_q, started_d;

  logic            xfer;
  logic [N_IN-1:0] idx;
  logic            lookup;

  // Loader: stream bit k (row k) lands at table bit W-1-k, i.e. ~k.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    tt_d     = tt_q;
    err_d    = err_q;
    xfer     = tt_valid && (state_q != COMMIT);
    idx      = (state_q == IDLE) ? '0 : cnt_q;

    if (state_q == COMMIT) begin
      tt_d    = shadow_q;
      state_d = IDLE;
    end else if (xfer) begin
      shadow_d[~idx] = tt_data;
      if (state_q == IDLE) begin
        err_d = 1'b0;
      end
      if (idx == LAST_IDX) begin
        if (tt_last) begin
          state_d = COMMIT;
        end else begin
          err_d    = 1'b1;
          shadow_d = '0;
          state_d  = IDLE;
        end
      end else if (tt_last) begin
        err_d    = 1'b1;
        shadow_d = '0;
        state_d  = IDLE;
      end else begin
        cnt_d   = idx + 1'b1;
        state_d = SHIFT;
      end
    end
  end

  assign lookup    = tt_q[~in];
  assign started_d = 1'b1;

`ifdef TT_LUT_GATE_GLITCH_FILTER_EN
  localparam logic [7:0] SETTLE_C = 8'(SETTLE);

  logic [N_IN-1:0] in_prev_q, in_prev_d;
  logic [7:0]      stab_q, stab_d;
  logic            settled;

  // stab counts consecutive cycles in has held its value, this cycle included.
  always_comb begin
    in_prev_d = in;
    if (in != in_prev_q) begin
      stab_d = 8'd1;
    end else if (stab_q >= SETTLE_C) begin
      stab_d = stab_q;
    end else begin
      stab_d = stab_q + 8'd1;
    end
    settled = (stab_d >= SETTLE_C);
    out_d   = settled ? lookup : out_q;
    valid_d = started_q && settled;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_prev_q <= '0;
      stab_q    <= '0;
    end else begin
      in_prev_q <= in_prev_d;
      stab_q    <= stab_d;
    end
  end
`else
  always_comb begin
    out_d   = lookup;
    valid_d = started_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shadow_q  <= '0;
      tt_q      <= TT_INIT;
      err_q     <= 1'b0;
      out_q     <= 1'b0;
      valid_q   <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      tt_q      <= tt_d;
      err_q     <= err_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      started_q <= started_d;
    end
  end

  // Outputs are forced low for the whole time rst is high, not just after its first edge.
  assign out       = out_q & ~rst;
  assign out_valid = valid_q & ~rst;
  assign tt_err    = err_q & ~rst;
  assign tt_ready  = ~rst & (state_q != COMMIT);

endmodule

`default_nettype wire

// File: tb/tb_tt_lut_gate.sv
// ============================================================================
// Module   : tb_tt_lut_gate
// Brief    : Self-checking bench for tt_lut_gate (table vectors, loads,
//            random lookups against a row-level model).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tt_lut_gate;

  localparam int N_IN = 4;
`ifdef TT_LUT_GATE_GLITCH_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 1;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_IN-1:0] in_v = '0;
  logic            tt_valid = 1'b0;
  logic            tt_data = 1'b0;
  logic            tt_last = 1'b0;
  logic            out, out_valid, tt_ready, tt_err;

  always #5 clk = ~clk;

  tt_lut_gate #(.N_IN(4), .TT_INIT(16'h0038), .SETTLE(4)) dut (
    .clk(clk), .rst(rst), .in(in_v), .out(out), .out_valid(out_valid),
    .tt_valid(tt_valid), .tt_data(tt_data), .tt_last(tt_last),
    .tt_ready(tt_ready), .tt_err(tt_err)
  );

  typedef struct {
    logic [3:0] in;
    logic       exp;
  } vec_t;

  vec_t vecs[16];
  logic row_val[16];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Default table: output is 1 only for rows 10, 11 and 12.
  task automatic model_reset();
    for (int r = 0; r < 16; r++) row_val[r] = (r == 10 || r == 11 || r == 12);
  endtask

  task automatic model_load(input logic [15:0] tbl);
    for (int r = 0; r < 16; r++) row_val[r] = tbl[15-r];
  endtask

  task automatic lookup(input logic [3:0] v);
    in_v = v;
    repeat (LAT) step();
    check("out", {31'd0, out}, {31'd0, row_val[v]});
    check("out_valid", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic send(input logic [15:0] tbl, input int nbits, input int last_at);
    for (int k = 0; k < nbits; k++) begin
      check("tt_ready_load", {31'd0, tt_ready}, 32'd1);
      tt_valid = 1'b1;
      tt_data  = tbl[15-k];
      tt_last  = (k == last_at);
      step();
      if (k == 0) check("tt_err_clear", {31'd0, tt_err}, 32'd0);
    end
    tt_valid = 1'b0;
    tt_last  = 1'b0;
  endtask

  task automatic full_load(input logic [15:0] tbl);
    send(tbl, 16, 15);
    check("tt_ready_commit", {31'd0, tt_ready}, 32'd0);
    check("tt_err_ok", {31'd0, tt_err}, 32'd0);
    step();
    check("tt_ready_idle", {31'd0, tt_ready}, 32'd1);
    model_load(tbl);
  endtask

  initial begin
    logic [15:0] tbl;
    int          last_at;

    model_reset();
    for (int i = 0; i < 16; i++) begin
      vecs[i].in  = 4'(i);
      vecs[i].exp = (i == 10 || i == 11 || i == 12);
    end

    // Reset state
    rst = 1'b1;
    #1;
    check("rst_out", {31'd0, out}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_tt_ready", {31'd0, tt_ready}, 32'd0);
    check("rst_tt_err", {31'd0, tt_err}, 32'd0);
    repeat (3) step();
    rst = 1'b0;
    step();
    check("valid_first_edge", {31'd0, out_valid}, 32'd0);
`ifdef TT_LUT_GATE_GLITCH_FILTER_EN
    repeat (4) step();
`else
    step();
`endif
    check("valid_second_edge", {31'd0, out_valid}, 32'd1);

    // Sweep against the default table
    for (int i = 0; i < 16; i++) begin
      in_v = vecs[i].in;
      repeat (LAT) step();
      check("sweep_out", {31'd0, out}, {31'd0, vecs[i].exp});
      check("sweep_valid", {31'd0, out_valid}, 32'd1);
    end

    // Full load of 16'h8001
    full_load(16'h8001);
    for (int i = 0; i < 16; i++) lookup(4'(i));

`ifndef TT_LUT_GATE_GLITCH_FILTER_EN
    // in changes in the COMMIT cycle: old table first, then the new one
    in_v = 4'd0;
    step();
    send(16'h0038, 16, 15);
    check("commit_ready", {31'd0, tt_ready}, 32'd0);
    in_v = 4'd10;
    step();
    check("commit_old_tbl", {31'd0, out}, 32'd0);
    model_load(16'h0038);
    step();
    check("commit_new_tbl", {31'd0, out}, 32'd1);
`endif

    // Early tt_last: error, table unchanged, next load clears the error
    full_load(16'h8001);
    send(16'hFFFF, 10, 9);
    check("early_last_err", {31'd0, tt_err}, 32'd1);
    check("early_last_ready", {31'd0, tt_ready}, 32'd1);
    for (int i = 0; i < 16; i++) lookup(4'(i));
    full_load(16'h5A3C);
    for (int i = 0; i < 16; i += 3) lookup(4'(i));

    // Reset in the middle of a load
    send(16'hFFFF, 7, -1);
    rst = 1'b1;
    #1;
    check("midrst_out", {31'd0, out}, 32'd0);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_ready", {31'd0, tt_ready}, 32'd0);
    repeat (2) step();
    check("midrst_out_hold", {31'd0, out}, 32'd0);
    rst = 1'b0;
    model_reset();
    repeat (LAT + 2) step();
    for (int i = 0; i < 16; i++) lookup(4'(i));

`ifdef TT_LUT_GATE_GLITCH_FILTER_EN
    // Toggling input never settles; holding it settles after 4 cycles
    in_v = 4'd0;
    repeat (6) step();
    check("flt_pre_out", {31'd0, out}, 32'd0);
    check("flt_pre_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      in_v = (i % 2 == 0) ? 4'd10 : 4'd0;
      repeat (2) begin
        step();
        check("flt_tog_valid", {31'd0, out_valid}, 32'd0);
        check("flt_tog_out", {31'd0, out}, 32'd0);
      end
    end
    in_v = 4'd10;
    repeat (3) begin
      step();
      check("flt_hold_valid", {31'd0, out_valid}, 32'd0);
      check("flt_hold_out", {31'd0, out}, 32'd0);
    end
    step();
    check("flt_settled_out", {31'd0, out}, 32'd1);
    check("flt_settled_valid", {31'd0, out_valid}, 32'd1);
`endif

    // Random loads (some malformed) and random lookups
    for (int it = 0; it < 8; it++) begin
      tbl = 16'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        last_at = int'($urandom_range(1, 14));
        send(tbl, last_at + 1, last_at);
        check("rnd_err", {31'd0, tt_err}, 32'd1);
      end else begin
        full_load(tbl);
      end
      for (int j = 0; j < 10; j++) lookup(4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tt_lut_gate.md
TT_LUT_GATE -- requirements
Module: tt_lut_gate

Interface
REQ-001 The block SHALL have parameter N_IN, default 4, meaning the number of logic inputs (legal range 1..6).
REQ-002 The block SHALL have parameter TT_INIT, default 16'h0038 (width 2^N_IN), meaning the truth table active after reset.
REQ-003 The block SHALL have parameter SETTLE, default 4, meaning the input-stability cycles required by the glitch filter (legal range 1..255).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be rising-edge clocked.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in, input, N_IN bits: logic inputs; in[N_IN-1] is in1 (MSB of the row index).
REQ-007 The block SHALL have port out, output, 1 bit: the registered gate output.
REQ-008 The block SHALL have port out_valid, output, 1 bit: high when out reflects the current in and the active table.
REQ-009 The block SHALL have port tt_valid, input, 1 bit: a serial truth-table bit is offered.
REQ-010 The block SHALL have port tt_data, input, 1 bit: the serial truth-table bit, row 0 first.
REQ-011 The block SHALL have port tt_last, input, 1 bit: marks the final bit of a load.
REQ-012 The block SHALL have port tt_ready, output, 1 bit: the loader accepts a bit.
REQ-013 The block SHALL have port tt_err, output, 1 bit: sticky load-length error.

Function
REQ-014 Row index SHALL be r = {in}; the selected table bit SHALL be tt[2^N_IN-1-r], so that TT_INIT=16'h0038 gives out=1 only for rows 1010, 1011 and 1100.
REQ-015 Evaluation SHALL be registered: out on the edge after cycle t SHALL equal the lookup of in and the active table sampled in cycle t (1-cycle latency).
REQ-016 The loader FSM SHALL have states IDLE, SHIFT and COMMIT; a bit is transferred only when tt_valid && tt_ready.
REQ-017 tt_ready SHALL be high in IDLE and SHIFT and low in COMMIT.
REQ-018 From IDLE, the first transfer SHALL clear tt_err and the bit counter, store the bit into the shadow table, and go to SHIFT (or evaluate tt_last directly if N_IN makes a single-bit table).
REQ-019 In SHIFT, each transfer SHALL store the bit at the shadow position given by the counter and increment the counter.
REQ-020 A transfer with tt_last=1 whose bit is bit 2^N_IN-1 SHALL move the FSM to COMMIT.
REQ-021 A transfer with tt_last=1 whose bit is not bit 2^N_IN-1, or a transfer with tt_last=0 at bit 2^N_IN-1, SHALL set tt_err, discard the shadow table and return to IDLE.
REQ-022 COMMIT SHALL last exactly one cycle, copy the shadow table to the active table atomically, and return to IDLE.
REQ-023 Lookups SHALL never observe a partially loaded table; the new table SHALL affect out from the edge after COMMIT.
REQ-024 A change of in simultaneous with COMMIT SHALL be evaluated against the old table in that cycle and against the new table from the next cycle.

Reset
REQ-025 While rst is high, the active table SHALL load TT_INIT, the FSM SHALL go to IDLE, and counters SHALL clear.
REQ-026 While rst is high, out SHALL be 0, out_valid 0, tt_err 0 and tt_ready 0.
REQ-027 rst asserted mid-load SHALL abort the load without altering TT_INIT.
REQ-028 out_valid SHALL rise at the earliest on the second edge after rst falls.

Configuration
REQ-029 With macro TT_LUT_GATE_GLITCH_FILTER_EN defined, a stability counter SHALL restart whenever in differs from its previous-cycle value.
REQ-030 With TT_LUT_GATE_GLITCH_FILTER_EN defined, out SHALL update and out_valid SHALL go high only after in has been unchanged for SETTLE consecutive cycles.
REQ-031 With TT_LUT_GATE_GLITCH_FILTER_EN defined, out_valid SHALL drop the cycle after any change of in.
REQ-032 With TT_LUT_GATE_GLITCH_FILTER_EN defined, a COMMIT SHALL re-evaluate out without restarting the settle count.
REQ-033 Without TT_LUT_GATE_GLITCH_FILTER_EN, no filter logic SHALL exist, and out_valid SHALL stay high from the first post-reset evaluation.

Verification
REQ-034 Reset, then sweep in=0..15 with default parameters -> out=1 exactly for in=10, 11 and 12, 1-cycle latency (filter off).
REQ-035 Load 16 bits encoding 16'h8001, tt_last on bit 15 -> tt_ready low for one COMMIT cycle; out=1 for in=0 and in=15 only.
REQ-036 Load with tt_last on bit 9 -> tt_err=1; table remains 16'h0038; the next load start clears tt_err.
REQ-037 Assert rst after 7 loaded bits -> table equals TT_INIT; out=0 and out_valid=0 during reset.
REQ-038 Filter on with SETTLE=4; toggle in between 1010 and 0000 every 2 cycles -> out_valid stays 0 and out holds; hold in=1010 -> out=1 and out_valid=1 after 4 stable cycles.
